// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - Wishbone widths, arbiter state encoding and a saturating counter helper
package wb_pkg;
  localparam int ADR_W = 30;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker returning a one-hot grant
module rr_pick #(
  parameter int NM = 2,
  parameter int PW = 1
) (
  input  logic [NM-1:0] req,
  input  logic [PW-1:0] ptr,
  output logic [NM-1:0] gnt,
  output logic [PW-1:0] idx
);
  logic [PW-1:0] k;
  logic          found;

  // Search starts one past the previous winner, wrapping explicitly at NM-1.
  always_comb begin
    gnt   = '0;
    idx   = ptr;
    found = 1'b0;
    k     = ptr;
    for (int i = 0; i < NM; i++) begin
      k = (k == PW'(NM - 1)) ? '0 : k + PW'(1);
      if (!found && req[k]) begin
        gnt[k] = 1'b1;
        idx    = k;
        found  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin Wishbone arbiter with locked-burst hold and bus watchdog
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int NM       = 2,
  parameter int TIMEOUT  = 255,
  parameter int LOCK_MAX = 15
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NM-1:0]       m_cyc_i,
  input  logic [NM-1:0]       m_stb_i,
  input  logic [NM-1:0]       m_we_i,
  input  logic [NM-1:0]       m_lock_i,
  input  logic [SEL_W*NM-1:0] m_sel_i,
  input  logic [ADR_W*NM-1:0] m_adr_i,
  input  logic [DAT_W*NM-1:0] m_dat_i,
  output logic [DAT_W-1:0]    m_dat_o,
  output logic [NM-1:0]       m_ack_o,
  output logic [NM-1:0]       m_err_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [SEL_W-1:0]    s_sel_o,
  output logic [ADR_W-1:0]    s_adr_o,
  output logic [DAT_W-1:0]    s_dat_o,
  input  logic [DAT_W-1:0]    s_dat_i,
  input  logic                s_ack_i,
  output logic [NM-1:0]       gnt_o
);
  localparam int PW = (NM > 1) ? $clog2(NM) : 1;

  state_t           state, state_n;
  logic [NM-1:0]    gnt, pick;
  logic [PW-1:0]    rr_ptr, pick_idx;
  logic [15:0]      cnt;
  logic             g_cyc, g_stb, g_we, g_lock;
  logic [SEL_W-1:0] g_sel;
  logic [ADR_W-1:0] g_adr;
  logic [DAT_W-1:0] g_dat;
  logic             wd_hit, lock_out;

  rr_pick #(.NM(NM), .PW(PW)) u_pick (
    .req (m_cyc_i),
    .ptr (rr_ptr),
    .gnt (pick),
    .idx (pick_idx)
  );

  // rr_ptr is loaded with the winner, so it doubles as the owner's mux select.
  assign g_cyc  = m_cyc_i[rr_ptr];
  assign g_stb  = m_stb_i[rr_ptr];
  assign g_we   = m_we_i[rr_ptr];
  assign g_lock = m_lock_i[rr_ptr];
  assign g_sel  = m_sel_i[int'(rr_ptr) * SEL_W +: SEL_W];
  assign g_adr  = m_adr_i[int'(rr_ptr) * ADR_W +: ADR_W];
  assign g_dat  = m_dat_i[int'(rr_ptr) * DAT_W +: DAT_W];

  // cnt holds completed unacked strobe cycles; an ack in the same cycle wins.
  assign wd_hit   = (state == ST_OWN) && g_stb && !s_ack_i && (cnt == 16'(TIMEOUT));
  assign lock_out = (cnt >= 16'(LOCK_MAX - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (|m_cyc_i) state_n = ST_OWN;
      ST_OWN: begin
        if (wd_hit)      state_n = ST_ERR;
        else if (!g_cyc) state_n = g_lock ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        if (g_cyc)                     state_n = ST_OWN;
        else if (!g_lock || lock_out)  state_n = ST_IDLE;
      end
      ST_ERR:  if (!g_cyc) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    if (state == ST_OWN) begin
      s_cyc_o = g_cyc;
      s_stb_o = g_stb;
      s_we_o  = g_we;
      s_sel_o = g_sel;
      s_adr_o = g_adr;
      s_dat_o = g_dat;
      m_ack_o = gnt & {NM{s_ack_i & g_stb}};
      m_err_o = wd_hit ? gnt : '0;
    end
  end

  // cnt is shared: watchdog age in OWN, idle-gap length in HOLD.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt    <= '0;
      rr_ptr <= PW'(NM - 1);
      cnt    <= '0;
    end else begin
      if (state == ST_IDLE && state_n == ST_OWN) begin
        gnt    <= pick;
        rr_ptr <= pick_idx;
      end else if (state_n == ST_IDLE) begin
        gnt <= '0;
      end
      if (state_n != state)
        cnt <= '0;
      else if (state == ST_HOLD || (state == ST_OWN && g_stb && !s_ack_i))
        cnt <= sat_inc(cnt);
      else
        cnt <= '0;
    end
  end

  assign m_dat_o = s_dat_i;
  assign gnt_o   = gnt;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter (NM=2, TIMEOUT=8, LOCK_MAX=15)
module tb_wb_arbiter;
  localparam int NM = 2;
  localparam logic [1:0] K_G = 2'd0, K_A = 2'd1, K_E = 2'd2;

  typedef struct packed {
    logic [1:0]    kind;
    logic [NM-1:0] val;
    logic [31:0]   at;
  } ev_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [NM-1:0] m_cyc, m_stb, m_we, m_lock, m_ack, m_err, gnt;
  logic [4*NM-1:0] m_sel;
  logic [30*NM-1:0] m_adr;
  logic [32*NM-1:0] m_dat;
  logic [31:0] m_rdat, s_wdat, s_rdat;
  logic s_cyc, s_stb, s_we, s_ack;
  logic [3:0] s_sel;
  logic [29:0] s_adr;

  logic [31:0] cycle = 0;
  logic [NM-1:0] prev_gnt = '0;
  ev_t exp_q[$];
  int checks = 0, passes = 0;
  logic [31:0] t;

  wb_arbiter #(.NM(NM), .TIMEOUT(8), .LOCK_MAX(15)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_lock_i(m_lock),
    .m_sel_i(m_sel), .m_adr_i(m_adr), .m_dat_i(m_dat),
    .m_dat_o(m_rdat), .m_ack_o(m_ack), .m_err_o(m_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_ack_i(s_ack),
    .gnt_o(gnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input int m, input logic on);
    m_cyc[m] = on;
    m_stb[m] = on;
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [NM-1:0] val, input logic [31:0] at);
    ev_t e;
    e.kind = kind; e.val = val; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h want %0h", name, act, req);
  endtask

  task automatic observe(input logic [1:0] kind, input logic [NM-1:0] val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL event: unexpected kind %0d val %b at cycle %0d", kind, val, cycle);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind == kind && e.val == val && e.at == cycle) passes++;
    else $display("FAIL event: got kind %0d val %b cycle %0d, want kind %0d val %b cycle %0d",
                  kind, val, cycle, e.kind, e.val, e.at);
  endtask

  // Monitor: grant changes, ack pulses and err pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (gnt != prev_gnt) begin
      observe(K_G, gnt);
      prev_gnt = gnt;
    end
    if (m_ack != '0) observe(K_A, m_ack);
    if (m_err != '0) observe(K_E, m_err);
    if (m_ack != '0 || m_err != '0) chk("ack_err_exclusive", 64'((m_ack != '0) && (m_err != '0)), 64'd0);
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    m_cyc = '0; m_stb = '0; m_lock = '0; s_ack = 1'b0;
    m_we  = 2'b10;
    m_sel = {4'h3, 4'hF};
    m_adr = {30'h2AAA_AAAA, 30'h000_0123};
    m_dat = {32'hDEAD_BEEF, 32'h1111_2222};
    s_rdat = 32'hA5A5_1234;

    #12;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_s_cyc", 64'(s_cyc), 64'd0);
    chk("rst_s_stb", 64'(s_stb), 64'd0);
    chk("rst_s_adr", 64'(s_adr), 64'd0);
    chk("rst_m_ack", 64'(m_ack), 64'd0);
    chk("rst_m_err", 64'(m_err), 64'd0);
    chk("rst_m_dat", 64'(m_rdat), 64'hA5A5_1234);
    tick();
    rst_n = 1'b1;
    tick();

    // Contention: both request, each does one access; grants alternate from master 0.
    t = cycle;
    drive(0, 1'b1); drive(1, 1'b1);
    for (int r = 0; r < 4; r++) begin
      int w;
      w = r % 2;
      expect_ev(K_G, NM'(1 << w), t + 1);
      tick();
      chk("mux_adr", 64'(s_adr), 64'(m_adr[30*w +: 30]));
      chk("mux_we", 64'(s_we), 64'(m_we[w]));
      chk("mux_dat", 64'(s_wdat), 64'(m_dat[32*w +: 32]));
      chk("mux_sel", 64'(s_sel), 64'(m_sel[4*w +: 4]));
      s_ack = 1'b1;
      expect_ev(K_A, NM'(1 << w), t + 1);
      tick();
      s_ack = 1'b0;
      drive(w, 1'b0);
      if (r == 3) drive(0, 1'b0);
      expect_ev(K_G, '0, t + 3);
      tick();
      if (r < 3) drive(w, 1'b1);
      t = t + 3;
    end

    // Locked burst: 4 beats with 3-cycle gaps; master 1 must wait for lock to fall.
    tick(); t = cycle;
    m_lock[0] = 1'b1;
    drive(0, 1'b1); drive(1, 1'b1);
    expect_ev(K_G, 2'b01, t + 1);
    for (int b = 0; b < 4; b++) begin
      logic [31:0] r;
      r = t + 32'(5 * b);
      tick();
      s_ack = 1'b1;
      expect_ev(K_A, 2'b01, r + 1);
      tick();
      s_ack = 1'b0;
      drive(0, 1'b0);
      if (b == 3) m_lock[0] = 1'b0;
      if (b < 3) begin
        tick();
        tick();
        if (b == 0) begin
          chk("hold_s_cyc", 64'(s_cyc), 64'd0);
          chk("hold_gnt", 64'(gnt), 64'b01);
        end
        tick();
        drive(0, 1'b1);
      end
    end
    expect_ev(K_G, '0, t + 18);
    expect_ev(K_G, 2'b10, t + 19);
    ticks(2);
    s_ack = 1'b1;
    expect_ev(K_A, 2'b10, t + 19);
    tick();
    s_ack = 1'b0;
    drive(1, 1'b0);
    expect_ev(K_G, '0, t + 21);
    tick();

    // Lock overrun: cyc low with lock held; release after the 15th HOLD cycle.
    tick(); t = cycle;
    m_lock[0] = 1'b1;
    drive(0, 1'b1); drive(1, 1'b1);
    expect_ev(K_G, 2'b01, t + 1);
    tick();
    s_ack = 1'b1;
    expect_ev(K_A, 2'b01, t + 1);
    tick();
    s_ack = 1'b0;
    drive(0, 1'b0);
    expect_ev(K_G, '0, t + 18);
    expect_ev(K_G, 2'b10, t + 19);
    ticks(15);
    chk("lock_14th_gnt", 64'(gnt), 64'b01);
    tick();
    chk("lock_15th_gnt", 64'(gnt), 64'd0);
    m_lock[0] = 1'b0;
    tick();
    s_ack = 1'b1;
    expect_ev(K_A, 2'b10, t + 19);
    tick();
    s_ack = 1'b0;
    drive(1, 1'b0);
    expect_ev(K_G, '0, t + 21);
    tick();

    // Watchdog: no ack; err pulses once after 8 unacked stb cycles.
    tick(); t = cycle;
    drive(0, 1'b1);
    expect_ev(K_G, 2'b01, t + 1);
    expect_ev(K_E, 2'b01, t + 9);
    ticks(9);
    chk("wd_err_cycle_stb", 64'(s_stb), 64'd1);
    tick();
    chk("err_s_stb", 64'(s_stb), 64'd0);
    chk("err_s_cyc", 64'(s_cyc), 64'd0);
    chk("err_gnt", 64'(gnt), 64'b01);
    ticks(2);
    drive(0, 1'b0);
    expect_ev(K_G, '0, t + 13);
    tick();

    // Ack in the cycle the count reaches TIMEOUT: ack wins, no err.
    tick(); t = cycle;
    drive(0, 1'b1);
    expect_ev(K_G, 2'b01, t + 1);
    ticks(9);
    s_ack = 1'b1;
    expect_ev(K_A, 2'b01, t + 9);
    tick();
    s_ack = 1'b0;
    drive(0, 1'b0);
    expect_ev(K_G, '0, t + 11);
    ticks(2);

    // Asynchronous reset mid-read.
    tick(); t = cycle;
    drive(1, 1'b1);
    expect_ev(K_G, 2'b10, t + 1);
    ticks(2);
    chk("pre_rst_s_stb", 64'(s_stb), 64'd1);
    expect_ev(K_G, '0, t + 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_s_cyc", 64'(s_cyc), 64'd0);
    chk("async_s_stb", 64'(s_stb), 64'd0);
    chk("async_gnt", 64'(gnt), 64'd0);
    ticks(2);
    rst_n = 1'b1;
    drive(0, 1'b1);
    t = cycle;
    expect_ev(K_G, 2'b01, t + 1);
    ticks(3);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
